// File: rtl/button_evt_pkg.sv
// rtl/button_evt_pkg.sv - register map, reset values and event word layout
package button_evt_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;
    localparam logic [15:0] DBNC_RESET        = 16'd1000;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DBNC   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_EVENT  = 4'hC;

    // Registers are word aligned, so adr[3:2] selects one of the four.
    typedef enum logic [1:0] {
        REG_CTRL   = OFF_CTRL[3:2],
        REG_DBNC   = OFF_DBNC[3:2],
        REG_STATUS = OFF_STATUS[3:2],
        REG_EVENT  = OFF_EVENT[3:2]
    } reg_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_OVF_BIT    = 16;

    localparam int EVT_VALID_BIT = 31;
    localparam int EVT_RISE_BIT  = 30;
    localparam int EVT_IDX_LSB   = 24;
    localparam int EVT_TS_LSB    = 0;

    function automatic logic [31:0] make_event(input logic       rise,
                                               input logic [2:0]  idx,
                                               input logic [15:0] ts);
        logic [31:0] w;
        w                       = '0;
        w[EVT_VALID_BIT]        = 1'b1;
        w[EVT_RISE_BIT]         = rise;
        w[EVT_IDX_LSB +: 3]     = idx;
        w[EVT_TS_LSB +: 16]     = ts;
        return w;
    endfunction

endpackage

// File: rtl/button_event_capture_if.sv
// rtl/button_event_capture_if.sv - Wishbone register bus bundle
interface button_event_capture_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
    modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/button_event_capture_core.sv
// rtl/button_event_capture_core.sv - synchronizers, debounce, event capture and register file
module button_event_capture_core
    import button_evt_pkg::*;
#(
    parameter int          NUM_IN     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    button_event_capture_if.slave bus,
    input  logic [NUM_IN-1:0]     btn_i,
    output logic [NUM_IN-1:0]     btn_state_o,
    output logic                  irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_IN-1:0] sync1_q, sync2_q, state_q, state_d, flip;
    logic [15:0]       cnt_q [NUM_IN];
    logic [15:0]       cnt_d [NUM_IN];
    logic [NUM_IN-1:0] pend_q, pend_d, rise_q, rise_d, push_onehot;
    logic [15:0]       dbnc_q, dbnc_d, dbnc_eff, ts_q;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ovf_q, ovf_d, ovf_set, ovf_clr;
    logic              ack_q, irq_q;
    logic [31:0]       dat_q, dat_d, rdata, status;
    logic              push_req;
    logic [2:0]        push_idx;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_data, fifo_count_ext;
    logic              hit, access, rd, wr, pop;
    reg_e              reg_sel;
    logic              unused_bits;

    assign hit     = bus.cyc & bus.stb & (bus.adr[31:4] == BASE_ADDR[31:4]);
    assign access  = hit & ~ack_q;
    assign rd      = access & ~bus.we;
    assign wr      = access & bus.we;
    assign reg_sel = reg_e'(bus.adr[3:2]);
    assign pop     = rd & (reg_sel == REG_EVENT) & ~fifo_empty;

    // The flip lands on the DBNC-th consecutive disagreeing cycle.
    always_comb begin
        dbnc_eff = (dbnc_q == 16'd0) ? 16'd1 : dbnc_q;
        flip     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (({1'b0, cnt_q[i]} + 17'd1) >= {1'b0, dbnc_eff}) flip[i] = 1'b1;
                else cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
        state_d = state_q ^ flip;
    end

    always_comb begin
        push_req    = 1'b0;
        push_idx    = '0;
        push_onehot = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_req = 1'b1;
                push_idx = 3'(i);
            end
        end
        if (push_req) push_onehot[push_idx] = 1'b1;
    end

    // A flip on an input whose previous event is still pending is lost.
    always_comb begin
        pend_d  = pend_q & ~push_onehot;
        rise_d  = rise_q;
        ovf_set = push_req & fifo_full & ~pop;
        if (ctrl_q[CTRL_EN_BIT]) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (flip[i]) begin
                    if (pend_q[i]) begin
                        ovf_set = 1'b1;
                    end else begin
                        pend_d[i] = 1'b1;
                        rise_d[i] = ~state_q[i];
                    end
                end
            end
        end
        ovf_clr = wr & (reg_sel == REG_STATUS) & bus.sel[2] & bus.dat_w[STAT_OVF_BIT];
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_comb begin
        fifo_count_ext                = 32'(fifo_count);
        status                        = '0;
        status[NUM_IN-1:0]            = state_q;
        status[STAT_COUNT_LSB +: 4]   = fifo_count_ext[3:0];
        status[STAT_OVF_BIT]          = ovf_q;
        case (reg_sel)
            REG_CTRL:   rdata = {30'd0, ctrl_q};
            REG_DBNC:   rdata = {16'd0, dbnc_q};
            REG_STATUS: rdata = status;
            default:    rdata = fifo_empty ? 32'd0 : fifo_data;
        endcase
        dat_d = rd ? rdata : 32'd0;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        dbnc_d = dbnc_q;
        if (wr && reg_sel == REG_CTRL && bus.sel[0]) ctrl_d = bus.dat_w[1:0];
        if (wr && reg_sel == REG_DBNC) begin
            if (bus.sel[0]) dbnc_d[7:0]  = bus.dat_w[7:0];
            if (bus.sel[1]) dbnc_d[15:8] = bus.dat_w[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
            pend_q  <= '0;
            rise_q  <= '0;
            ts_q    <= '0;
            ctrl_q  <= '0;
            dbnc_q  <= DBNC_RESET;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
            pend_q  <= pend_d;
            rise_q  <= rise_d;
            ts_q    <= ts_q + 16'd1;
            ctrl_q  <= ctrl_d;
            dbnc_q  <= dbnc_d;
            ovf_q   <= ovf_d;
            ack_q   <= access;
            dat_q   <= dat_d;
            irq_q   <= ctrl_q[CTRL_IRQ_EN_BIT] & ((fifo_count != '0) | ovf_q);
        end
    end

    evt_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req),
        .data_i  (make_event(rise_q[push_idx], push_idx, ts_q)),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.ack     = ack_q;
    assign bus.dat_r   = dat_q;
    assign btn_state_o = state_q;
    assign irq_o       = irq_q;
    assign unused_bits = ^{bus.adr[1:0], bus.sel[3], bus.dat_w[31:17], fifo_count_ext[31:4]};
endmodule

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - synchronous FIFO; a pop frees room for a same-cycle push when full
module evt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/button_event_capture.sv
// rtl/button_event_capture.sv - debounced button event capture with Wishbone register access
module button_event_capture
    import button_evt_pkg::*;
#(
    parameter int          NUM_IN     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IN-1:0] btn_i,
    output logic [NUM_IN-1:0] btn_state_o,
    output logic              irq_o
);
    button_event_capture_if bus_if ();

    assign bus_if.cyc   = wbs_cyc_i;
    assign bus_if.stb   = wbs_stb_i;
    assign bus_if.we    = wbs_we_i;
    assign bus_if.sel   = wbs_sel_i;
    assign bus_if.adr   = wbs_adr_i;
    assign bus_if.dat_w = wbs_dat_i;
    assign wbs_ack_o    = bus_if.ack;
    assign wbs_dat_o    = bus_if.dat_r;

    button_event_capture_core #(
        .NUM_IN     (NUM_IN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_core (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .bus         (bus_if.slave),
        .btn_i       (btn_i),
        .btn_state_o (btn_state_o),
        .irq_o       (irq_o)
    );
endmodule

// File: doc/button_event_capture.md
BUTTON_EVENT_CAPTURE -- requirements
Module: button_event_capture

Interface
REQ-001 SHALL have parameter NUM_IN, default 8: number of button inputs (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address.
REQ-004 SHALL have port wb_clk_i, input, 1: the single clock.
REQ-005 SHALL have port wb_rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have Wishbone slave ports wbs_cyc_i, wbs_stb_i and wbs_we_i, inputs, 1 each: bus cycle, strobe and write enable.
REQ-007 SHALL have ports wbs_sel_i (input, 4), wbs_adr_i (input, 32) and wbs_dat_i (input, 32): byte selects, address and write data.
REQ-008 SHALL have ports wbs_ack_o (output, 1) and wbs_dat_o (output, 32): acknowledge and read data.
REQ-009 SHALL have port btn_i, input, NUM_IN: raw asynchronous pad inputs.
REQ-010 SHALL have port btn_state_o, output, NUM_IN: debounced button levels for the downstream user logic.
REQ-011 SHALL have port irq_o, output, 1: level interrupt.

Function
REQ-012 SHALL pass each btn_i bit through a 2-flop synchronizer.
REQ-013 SHALL flip a debounced bit only after its synchronized value differs from it for DBNC consecutive cycles; any agreeing cycle clears that bit's counter. DBNC=0 SHALL act as 1.
REQ-014 SHALL, on each debounced flip with CTRL.EN=1, set that input's pending bit; a flip while already pending is lost and SHALL set OVF.
REQ-015 SHALL push one pending event per cycle, lowest index first, clearing its pending bit.
REQ-016 SHALL form the event word as {valid[31], rise[30], 0[29:27], idx[26:24], 0[23:16], ts[15:0]}, where ts is a free-running 16-bit cycle counter that wraps 0xFFFF->0 and is sampled at push.
REQ-017 SHALL, on a push to a full FIFO, drop the event and set OVF; a push and a pop in the same cycle at full SHALL succeed, leaving the count unchanged.
REQ-018 SHALL decode a register access when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4]==BASE_ADDR[31:4]); other addresses SHALL get no ack.
REQ-019 SHALL assert wbs_ack_o for exactly one cycle, registered one cycle after the decode; it SHALL not re-ack while ack is high, so the minimum is 2 cycles per access.
REQ-020 SHALL map the registers as follows:
- 0x0 CTRL RW: EN[0], IRQ_EN[1].
- 0x4 DBNC RW: [15:0].
- 0x8 STATUS: state[7:0] RO, count[11:8] RO, OVF[16] W1C.
- 0xC EVENT RO: a read pops the FIFO and returns the event word; a read when empty returns 0 with no pop.
REQ-021 SHALL honour wbs_sel_i per byte on writes; writes to RO fields SHALL be ignored.
REQ-022 SHALL drive wbs_dat_o only on the ack cycle and 0 otherwise.
REQ-023 SHALL register irq_o = IRQ_EN & ((count!=0) | OVF).
REQ-024 SHALL, with EN=0, keep debouncing and driving btn_state_o, set no pending bits, and retain FIFO contents.

Reset
REQ-025 SHALL, on wb_rst_i, clear all of the following on the next edge: synchronizers, counters, debounced state, pending bits, FIFO (empty), ts, CTRL, OVF, wbs_ack_o, wbs_dat_o and irq_o.
REQ-026 SHALL reset DBNC to 16'd1000.
REQ-027 SHALL abort an in-flight bus access when reset is asserted mid-access, with no ack.

Structure
REQ-028 SHALL place the register offsets, DBNC reset value, event field positions and BASE_ADDR default in package button_evt_pkg.
REQ-029 SHALL implement the FIFO as sub-module evt_fifo, a synchronous FIFO with push/pop/full/empty/count.

Verification
REQ-030 Reset: reset then read 0x4 -> 0x0000_03E8; read 0x8 -> 0; irq_o=0.
REQ-031 Debounce: DBNC=4, EN=1, btn_i[2] high for 3 cycles then low -> no event. High for 10 cycles -> one event, read 0xC -> 0xC200_xxxx, btn_state_o[2]=1.
REQ-032 Simultaneous: btn_i[5] and btn_i[1] rise in the same cycle -> event idx1 popped before idx5, and ts5 = ts1 + 1.
REQ-033 Overflow: 9 rise/fall edges with the FIFO empty and DEPTH 8 -> count 8, OVF=1, irq_o=1 (IRQ_EN=1). Writing 0x8 with 0x1_0000 clears OVF; 8 pops, then the 9th read returns 0 and irq_o drops.
REQ-034 Bus: access to BASE_ADDR+0x10 -> no ack within 16 cycles. A sel=4'b0001 write of 0xFFFF_FFFF to 0x4 -> DBNC=0x03FF.
REQ-035 Reset mid-operation: wb_rst_i during a FIFO push with an access pending -> no ack, count=0, CTRL=0.
